sw_run_ctrl: RTL and testbench
==============================

Name: sw_run_ctrl

Overview:
Front-panel conditioning and run-control stage that sits directly upstream of the pipeline CPU, RAM and display logic on the FPGA board. It synchronises and debounces the 16 board switches, then runs a run/pause/single-step state machine. It produces a one-cycle CPU clock-enable tick at a selectable rate, the CPU reset and pause levels, and the RAM-display address and display-mode select.

Parameters:
DEBOUNCE_CYCLES, 1000000, sample period of the switch debouncer in clk cycles (10 ms at 100 MHz)
DIV_FAST, 50000000, clk cycles per CPU tick when SW[4]=1
DIV_SLOW, 100000000, clk cycles per CPU tick when SW[4]=0
RST_HOLD_CYCLES, 16, minimum cpu_rst assertion length in clk cycles

Ports:
clk  in  1  board clock; all state is clocked on its rising edge
rst  in  1  reset, asynchronous, active-high
SW  in  16  raw switches: [0] start, [1] pause, [2] reset request, [3] step, [4] speed, [7:5] display_op, [15:8] display word address
cpu_tick  out  1  one-clk-wide CPU advance pulse
cpu_rst  out  1  reset level to CPU/RAM
pause  out  1  high whenever state is not RUN
run_state  out  2  0=RST_HOLD, 1=IDLE, 2=RUN, 3=PAUSED
ram_display_addr  out  10  {2'b00, debounced SW[15:8]}
display_op  out  3  debounced SW[7:5]
tick_count  out  32  number of cpu_tick pulses issued since the last cpu_rst

Behaviour:
- Reset values (rst high): state RST_HOLD, cpu_tick=0, cpu_rst=1, pause=1, run_state=0, ram_display_addr=0, display_op=0, tick_count=0. Synchronisers, debounced switches, sample counter, divider and hold counter are all cleared to 0.
- Synchroniser: 2-flop synchroniser on each SW bit.
- Debouncer:
  - Shared sample counter runs 0..DEBOUNCE_CYCLES-1, then wraps.
  - At wrap: smp <= sync; deb[i] <= sync[i] only where sync[i]==smp[i], i.e. two consecutive samples agree.
  - Worst-case latency from a raw edge to deb: 2*DEBOUNCE_CYCLES+2 cycles.
  - Glitches shorter than one sample period never reach deb.
- Edge detect: step_rise = deb[3] & ~deb3_q, where deb3_q is deb[3] delayed one cycle.
- FSM priority order: deb[2] high forces RST_HOLD from any state, and the hold counter is reloaded.
  - RST_HOLD: cpu_rst=1; tick_count cleared; hold counter counts up. Exits to IDLE when count reaches RST_HOLD_CYCLES-1 and deb[2]=0.
  - IDLE: no ticks. Go to RUN when deb[0]=1. Divider cleared on entry to RUN.
  - RUN: divider counts 0..DIV-1, where DIV is DIV_FAST or DIV_SLOW per deb[4]. cpu_tick=1 on the cycle the divider equals DIV-1, then the divider wraps to 0.
    - If the speed select changes so that divider >= new DIV-1, tick on the next cycle and wrap.
    - deb[0]=0 goes to IDLE (takes precedence); otherwise deb[1]=1 goes to PAUSED.
  - PAUSED: divider held.
    - deb[0]=0 goes to IDLE.
    - Otherwise deb[1]=0 goes to RUN, divider cleared.
    - Otherwise step_rise gives exactly one cpu_tick, registered next cycle, and stays in PAUSED.
    - Step edge coinciding with pause release: the step is discarded.
- cpu_tick is registered and never high for two consecutive cycles. It is never high in RST_HOLD or IDLE, nor on the cycle the FSM leaves RUN.
- tick_count increments on every cpu_tick, saturates at 0xFFFFFFFF, and is cleared while cpu_rst=1.
- ram_display_addr and display_op are registered copies of deb bits, valid in all states including RST_HOLD.
- rst asserted mid-RUN: outputs go to reset values immediately (asynchronously); an in-flight tick is lost.

Optional Feature:
SW_RUN_CTRL_STEP_EN
- Defined: single-step support in PAUSED as above.
- Undefined: SW[3] is ignored, the step edge detector is not built, and PAUSED issues no ticks.

Test Plan:
Common setup: DEBOUNCE_CYCLES=4, DIV_FAST=2, DIV_SLOW=8, RST_HOLD_CYCLES=4.
1. Reset: pulse rst, keep SW=0 -> cpu_rst stays 1 for at least 4 cycles, then run_state=1, pause=1, cpu_tick never high.
2. Run and speed: SW[0]=1, SW[4]=0 -> ticks every 8 clk, tick_count=3 after 24 clk in RUN; set SW[4]=1 -> ticks every 2 clk after debounce latency.
3. Debounce: 3-cycle glitch on SW[1] while in RUN -> no PAUSED entry and tick cadence unchanged; steady SW[1]=1 -> PAUSED within 10 cycles, ticks stop.
4. Step: in PAUSED, toggle SW[3] 0->1->0 three times with 20 clk per level -> exactly 3 cpu_tick pulses, tick_count +3. With the macro undefined -> 0 pulses.
5. Reset mid-run: tick_count=5 in RUN, then SW[2]=1 -> state RST_HOLD, cpu_rst=1, tick_count=0. Release SW[2] with SW[0]=1 -> IDLE, then RUN.
6. Display passthrough: SW[15:8]=0xA5, SW[7:5]=3'b110 -> after debounce ram_display_addr=10'h0A5, display_op=6 in every state.

Source files
------------

// File: rtl/sw_run_ctrl.sv
// Switch synchroniser/debouncer feeding a CPU run/pause/step controller.
// Define SW_RUN_CTRL_STEP_EN to enable single-step ticks in PAUSED.
module sw_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned DIV_FAST        = 50000000,
    parameter int unsigned DIV_SLOW        = 100000000,
    parameter int unsigned RST_HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] SW,
    output logic        cpu_tick,
    output logic        cpu_rst,
    output logic        pause,
    output logic [1:0]  run_state,
    output logic [9:0]  ram_display_addr,
    output logic [2:0]  display_op,
    output logic [31:0] tick_count
);
    typedef enum logic [1:0] {
        S_RST_HOLD = 2'd0,
        S_IDLE     = 2'd1,
        S_RUN      = 2'd2,
        S_PAUSED   = 2'd3
    } state_e;

    localparam logic [31:0] SMP_LAST  = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD_CYCLES - 1);
    localparam logic [31:0] FAST_LAST = 32'(DIV_FAST - 1);
    localparam logic [31:0] SLOW_LAST = 32'(DIV_SLOW - 1);

    logic [15:0] sync1_q, sync2_q;
    logic [15:0] smp_q, smp_d, deb_q, deb_d, agree;
    logic [31:0] smp_cnt_q, smp_cnt_d;
    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d, div_q, div_d, div_last;
    logic [31:0] tick_count_q, tick_count_d;
    logic        tick_q, tick_d, step_rise;
    logic [9:0]  addr_q, addr_d;
    logic [2:0]  op_q, op_d;

`ifdef SW_RUN_CTRL_STEP_EN
    logic deb3_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) deb3_q <= 1'b0;
        else     deb3_q <= deb_q[3];
    end
    assign step_rise = deb_q[3] & ~deb3_q;
`else
    logic step_unused;
    assign step_unused = deb_q[3];
    assign step_rise   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            smp_q        <= '0;
            deb_q        <= '0;
            smp_cnt_q    <= '0;
            state_q      <= S_RST_HOLD;
            hold_q       <= '0;
            div_q        <= '0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            addr_q       <= '0;
            op_q         <= '0;
        end else begin
            sync1_q      <= SW;
            sync2_q      <= sync1_q;
            smp_q        <= smp_d;
            deb_q        <= deb_d;
            smp_cnt_q    <= smp_cnt_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            div_q        <= div_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
        end
    end

    // A bit only moves when two consecutive samples agree.
    assign agree = ~(sync2_q ^ smp_q);

    always_comb begin
        smp_cnt_d = smp_cnt_q + 32'd1;
        smp_d     = smp_q;
        deb_d     = deb_q;
        if (smp_cnt_q >= SMP_LAST) begin
            smp_cnt_d = '0;
            smp_d     = sync2_q;
            deb_d     = (deb_q & ~agree) | (sync2_q & agree);
        end
        addr_d = {2'b00, deb_q[15:8]};
        op_d   = deb_q[7:5];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RST_HOLD: if (hold_q >= HOLD_LAST) state_d = S_IDLE;
            S_IDLE:     if (deb_q[0]) state_d = S_RUN;
            S_RUN: begin
                if (!deb_q[0])    state_d = S_IDLE;
                else if (deb_q[1]) state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (!deb_q[0])     state_d = S_IDLE;
                else if (!deb_q[1]) state_d = S_RUN;
            end
            default: state_d = S_RST_HOLD;
        endcase
        if (deb_q[2]) state_d = S_RST_HOLD;
    end

    assign div_last = deb_q[4] ? FAST_LAST : SLOW_LAST;

    // Ticks are only issued when the FSM stays put, so none leak on exit.
    always_comb begin
        tick_d = 1'b0;
        div_d  = div_q;
        hold_d = hold_q;
        unique case (state_q)
            S_RST_HOLD: hold_d = hold_q + 32'd1;
            S_IDLE:     div_d  = '0;
            S_RUN: begin
                if (state_d == S_RUN) begin
                    if (div_q >= div_last) begin
                        tick_d = 1'b1;
                        div_d  = '0;
                    end else begin
                        div_d = div_q + 32'd1;
                    end
                end
            end
            S_PAUSED: begin
                if (state_d == S_RUN)         div_d  = '0;
                else if (state_d == S_PAUSED) tick_d = step_rise;
            end
            default: ;
        endcase
        if (deb_q[2]) hold_d = '0;
        tick_count_d = tick_count_q;
        if (state_d == S_RST_HOLD)
            tick_count_d = '0;
        else if (tick_d && tick_count_q != '1)
            tick_count_d = tick_count_q + 32'd1;
    end

    always_comb begin
        cpu_rst   = (state_q == S_RST_HOLD);
        pause     = (state_q != S_RUN);
        run_state = state_q;
    end

    assign cpu_tick         = tick_q;
    assign tick_count       = tick_count_q;
    assign ram_display_addr = addr_q;
    assign display_op       = op_q;

endmodule

// File: tb/tb_sw_run_ctrl.sv
// Bench for sw_run_ctrl: cycle model compared every cycle plus directed
// literal checks of reset, run speeds, debounce, step and display paths.
module tb_sw_run_ctrl;
    localparam int DEB = 4;
    localparam int FAST = 2;
    localparam int SLOW = 8;
    localparam int HOLD = 4;
`ifdef SW_RUN_CTRL_STEP_EN
    localparam int STEP_N = 3;
    localparam bit STEP = 1'b1;
`else
    localparam int STEP_N = 0;
    localparam bit STEP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] SW = '0;
    logic        cpu_tick, cpu_rst, pause;
    logic [1:0]  run_state;
    logic [9:0]  ram_display_addr;
    logic [2:0]  display_op;
    logic [31:0] tick_count;

    sw_run_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .DIV_FAST(FAST),
        .DIV_SLOW(SLOW),
        .RST_HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .SW(SW),
        .cpu_tick(cpu_tick),
        .cpu_rst(cpu_rst),
        .pause(pause),
        .run_state(run_state),
        .ram_display_addr(ram_display_addr),
        .display_op(display_op),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int nticks = 0;
    bit paused_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Behavioural model: state 0=hold 1=idle 2=run 3=paused
    int          m_state, m_hold, m_div, m_ph;
    bit          m_tick, m_prev3;
    logic [31:0] m_cnt;
    logic [9:0]  m_addr;
    logic [2:0]  m_op;
    logic [15:0] m_p0, m_p1, m_smp, m_deb;

    task automatic model_step();
        logic [15:0] d, agree;
        int nxt, per;
        bit tk;
        if (rst) begin
            m_state = 0; m_hold = 0; m_div = 0; m_ph = 0;
            m_tick = 0; m_prev3 = 0; m_cnt = 0; m_addr = 0; m_op = 0;
            m_p0 = 0; m_p1 = 0; m_smp = 0; m_deb = 0;
            return;
        end
        d = m_deb;
        per = d[4] ? FAST : SLOW;
        nxt = m_state;
        tk = 0;
        if (d[2]) begin
            nxt = 0;
            m_hold = 0;
        end else begin
            case (m_state)
                0: begin
                    if (m_hold == HOLD - 1) nxt = 1;
                    m_hold++;
                end
                1: if (d[0]) begin nxt = 2; m_div = 0; end
                2: begin
                    if (!d[0]) nxt = 1;
                    else if (d[1]) nxt = 3;
                    else begin
                        m_div++;
                        if (m_div >= per) begin tk = 1; m_div = 0; end
                    end
                end
                default: begin
                    if (!d[0]) nxt = 1;
                    else if (!d[1]) begin nxt = 2; m_div = 0; end
                    else if (STEP && d[3] && !m_prev3) tk = 1;
                end
            endcase
        end
        if (nxt == 0) m_cnt = 0;
        else if (tk && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        m_addr = {2'b00, d[15:8]};
        m_op = d[7:5];
        m_prev3 = d[3];
        if (m_ph == DEB - 1) begin
            agree = ~(m_p1 ^ m_smp);
            m_deb = (m_deb & ~agree) | (m_p1 & agree);
            m_smp = m_p1;
        end
        m_ph = (m_ph + 1) % DEB;
        m_p1 = m_p0;
        m_p0 = SW;
        m_tick = tk;
        m_state = nxt;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("m_tick", 32'(cpu_tick), 32'(m_tick));
            chk("m_rst", 32'(cpu_rst), 32'(m_state == 0));
            chk("m_pause", 32'(pause), 32'(m_state != 2));
            chk("m_state", 32'(run_state), m_state);
            chk("m_count", tick_count, m_cnt);
            chk("m_addr", 32'(ram_display_addr), 32'(m_addr));
            chk("m_op", 32'(display_op), 32'(m_op));
        end
    end

    task automatic step1();
        @(negedge clk);
        if (cpu_tick === 1'b1) nticks++;
        if (run_state === 2'd3) paused_seen = 1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim,
                              input string nm);
        int n = 0;
        while (run_state !== s && n < lim) begin
            step1();
            n++;
        end
        chk(nm, 32'(run_state), 32'(s));
    endtask

    initial begin
        int n, t0;
        logic [31:0] c0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_state", 32'(run_state), 32'd0);
        chk("rst_pause", 32'(pause), 32'd1);
        chk("rst_tick", 32'(cpu_tick), 32'd0);
        chk("rst_count", tick_count, 32'd0);
        chk("rst_addr", 32'(ram_display_addr), 32'd0);
        chk("rst_op", 32'(display_op), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        n = 0;
        do begin
            step1();
            n++;
        end while (cpu_rst === 1'b1 && n < 20);
        chk("hold_len", n, 32'd4);
        chk("idle_state", 32'(run_state), 32'd1);
        chk("idle_pause", 32'(pause), 32'd1);

        SW[0] = 1'b1;
        wait_state(2'd2, 20, "enter_run");
        t0 = nticks;
        repeat (24) step1();
        chk("slow_ticks", nticks - t0, 32'd3);
        chk("slow_count", tick_count, 32'd3);

        SW[4] = 1'b1;
        repeat (16) step1();
        t0 = nticks;
        repeat (10) step1();
        chk("fast_ticks", nticks - t0, 32'd5);

        SW[15:8] = 8'hA5;
        SW[7:5] = 3'b110;
        repeat (12) step1();
        paused_seen = 0;
        t0 = nticks;
        SW[1] = 1'b1;
        repeat (3) step1();
        SW[1] = 1'b0;
        repeat (21) step1();
        chk("glitch_ticks", nticks - t0, 32'd12);
        chk("glitch_nopause", 32'(paused_seen), 32'd0);
        chk("run_addr", 32'(ram_display_addr), 32'h0A5);
        chk("run_op", 32'(display_op), 32'd6);

        SW[1] = 1'b1;
        wait_state(2'd3, 14, "enter_pause");
        t0 = nticks;
        repeat (20) step1();
        chk("pause_ticks", nticks - t0, 32'd0);
        chk("pause_level", 32'(pause), 32'd1);
        chk("pause_addr", 32'(ram_display_addr), 32'h0A5);
        chk("pause_op", 32'(display_op), 32'd6);

        c0 = tick_count;
        t0 = nticks;
        for (int i = 0; i < 3; i++) begin
            SW[3] = 1'b1;
            repeat (20) step1();
            SW[3] = 1'b0;
            repeat (20) step1();
        end
        chk("step_ticks", nticks - t0, STEP_N);
        chk("step_count", tick_count, c0 + STEP_N);
        chk("step_state", 32'(run_state), 32'd3);

        SW[1] = 1'b0;
        wait_state(2'd2, 14, "resume_run");
        c0 = tick_count;
        repeat (10) step1();
        chk("resume_count", tick_count, c0 + 5);

        SW[2] = 1'b1;
        wait_state(2'd0, 14, "enter_hold");
        chk("hold_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("hold_count", tick_count, 32'd0);
        chk("hold_addr", 32'(ram_display_addr), 32'h0A5);
        chk("hold_op", 32'(display_op), 32'd6);
        SW[2] = 1'b0;
        wait_state(2'd1, 24, "hold_to_idle");
        chk("idle_addr", 32'(ram_display_addr), 32'h0A5);
        chk("idle_op", 32'(display_op), 32'd6);
        wait_state(2'd2, 4, "idle_to_run");
        chk("rerun_op", 32'(display_op), 32'd6);

        repeat (5) step1();
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(run_state), 32'd0);
        chk("arst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("arst_tick", 32'(cpu_tick), 32'd0);
        chk("arst_count", tick_count, 32'd0);
        chk("arst_addr", 32'(ram_display_addr), 32'd0);
        chk("arst_op", 32'(display_op), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        wait_state(2'd1, 20, "post_rst_idle");
        wait_state(2'd2, 20, "post_rst_run");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
